x9_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the X9 core datapath: FETCH -> EXEC -> (MEMWAIT) -> WB.
- Owns the program counter and gates the instruction-ROM fetch and the register-file write enable.
- Consumes decoder/ALU control from the current instruction and raises done at program halt.
- Sits inside top_level between the instruction ROM, the decoder and reg_file. top_level's done output is this block's done.

---
 rtl/x9_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_x9_seq_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/x9_seq_ctrl.sv
// X9 core sequencer: walks FETCH -> EXEC -> (MEMWAIT) -> WB, owns the PC,
// counts retired instructions and halts on HALT or on a data-memory timeout.
module x9_seq_ctrl #(
  parameter int unsigned PC_W        = 10,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             mem_op,
  input  logic             mem_ready,
  input  logic             branch_en,
  input  logic             branch_taken,
  input  logic             br_abs,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc,
  output logic             fetch_en,
  output logic             wb_en,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] ToLimit = TO_W'(MEM_TIMEOUT);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StExec    = 3'd2,
    StMemWait = 3'd3,
    StWb      = 3'd4,
    StHalt    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              fault_q, fault_d;
  logic [TO_W-1:0]   to_inc;
  logic              to_hit;
  logic              take_branch;

  assign to_inc      = to_q + TO_W'(1);
  assign to_hit      = (to_inc == ToLimit);
  assign take_branch = branch_en & branch_taken;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StFetch;
      StFetch:   state_d = StExec;
      StExec: begin
        if (halt)        state_d = StHalt;
        else if (mem_op) state_d = StMemWait;
        else             state_d = StWb;
      end
      // A ready on the limit cycle still completes the access.
      StMemWait: begin
        if (mem_ready)   state_d = StWb;
        else if (to_hit) state_d = StHalt;
      end
      StWb:      state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
  end

  // Moore strobes
  always_comb begin
    fetch_en = 1'b0;
    wb_en    = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StFetch: fetch_en = 1'b1;
      StWb:    wb_en    = 1'b1;
      StHalt:  done     = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      to_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    fault_d = fault_q;
    unique case (state_q)
      StExec: to_d = '0;
      StMemWait: begin
        if (!mem_ready) begin
          to_d = to_inc;
          if (to_hit) fault_d = 1'b1;
        end
      end
      StWb: begin
        // Modular add of a PC_W-bit two's-complement offset equals the sign-extended sum.
        if (take_branch && br_abs) pc_d = target;
        else if (take_branch)      pc_d = pc_q + target;
        else                       pc_d = pc_q + PC_W'(1);
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign pc        = pc_q;
  assign instr_cnt = cnt_q;
  assign fault     = fault_q;
  assign state     = state_q;

endmodule

// File: tb/tb_x9_seq_ctrl.sv
// Bench for x9_seq_ctrl: builds per-cycle stimulus and expected outputs from an
// instruction-level model, then replays it against the DUT.
module tb_x9_seq_ctrl;

  localparam int PC_W = 10;
  localparam int CNT_W = 5;
  localparam int TMO = 15;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam int StIdle = 0, StFetch = 1, StExec = 2, StMem = 3, StWb = 4, StHalt = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, halt = 1'b0, mem_op = 1'b0, mem_ready = 1'b0;
  logic branch_en = 1'b0, branch_taken = 1'b0, br_abs = 1'b0;
  logic [PC_W-1:0] target = '0;
  logic [PC_W-1:0] pc;
  logic fetch_en, wb_en, done, fault;
  logic [CNT_W-1:0] instr_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  x9_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .mem_op(mem_op),
    .mem_ready(mem_ready), .branch_en(branch_en), .branch_taken(branch_taken),
    .br_abs(br_abs), .target(target), .pc(pc), .fetch_en(fetch_en), .wb_en(wb_en),
    .done(done), .fault(fault), .instr_cnt(instr_cnt), .state(state)
  );

  typedef struct {
    int rst, start, halt, mem_op, mem_ready, br_en, br_taken, br_abs, target, achk, lpc;
    int st, pc, fe, wb, dn, ft, cnt;
  } cyc_t;

  cyc_t q[$];
  int m_st = StIdle, m_pc = 0, m_cnt = 0, m_fault = 0, pend_lpc = -1;
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: random inputs, expected outputs from the model's current view.
  function automatic cyc_t mk();
    cyc_t c;
    c.rst = 1; c.achk = 0; c.lpc = pend_lpc; pend_lpc = -1;
    c.start = int'($urandom_range(1)); c.halt = int'($urandom_range(1));
    c.mem_op = int'($urandom_range(1)); c.mem_ready = int'($urandom_range(1));
    c.br_en = int'($urandom_range(1)); c.br_taken = int'($urandom_range(1));
    c.br_abs = int'($urandom_range(1)); c.target = int'($urandom_range(1023));
    c.st = m_st; c.pc = m_pc; c.fe = int'(m_st == StFetch); c.wb = int'(m_st == StWb);
    c.dn = int'(m_st == StHalt); c.ft = m_fault; c.cnt = m_cnt;
    return c;
  endfunction

  task automatic rst_cyc();
    cyc_t c = mk();
    c.rst = 0; c.achk = 1; q.push_back(c);
    m_st = StIdle; m_pc = 0; m_cnt = 0; m_fault = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_t c = mk();
      c.start = 0; q.push_back(c);
    end
  endtask

  task automatic go();
    cyc_t c = mk();
    c.start = 1; q.push_back(c); m_st = StFetch;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) q.push_back(mk());
  endtask

  task automatic pin(input int v);
    chk("model_pc_pin", m_pc, v);
    pend_lpc = v;
  endtask

  // kind: 0 = ALU op, 1 = load/store, 2 = HALT (also asserts branch and mem_op).
  task automatic instr(input int kind, input int be, input int bt, input int ba, input int tg,
                       input int w, input int rdy, input int rst_wb);
    cyc_t c;
    int off;
    q.push_back(mk());
    m_st = StExec;
    c = mk();
    c.halt = int'(kind == 2); c.mem_op = int'(kind != 0);
    if (kind == 2) begin c.br_en = 1; c.br_taken = 1; end
    q.push_back(c);
    if (kind == 2) begin m_st = StHalt; return; end
    if (kind == 1) begin
      m_st = StMem;
      if (!rdy) w = TMO;
      for (int k = 1; k <= w; k++) begin
        c = mk();
        c.mem_ready = int'(rdy != 0 && k == w);
        q.push_back(c);
      end
      if (!rdy) begin m_st = StHalt; m_fault = 1; return; end
    end
    m_st = StWb;
    c = mk();
    if (be != 0) begin c.br_en = 1; c.br_taken = bt; c.br_abs = ba; c.target = tg; end
    else c.br_en = 0;
    if (rst_wb != 0) begin
      c.rst = 0; c.achk = 1; q.push_back(c);
      m_st = StIdle; m_pc = 0; m_cnt = 0; m_fault = 0;
      return;
    end
    q.push_back(c);
    if (c.br_en != 0 && c.br_taken != 0 && c.br_abs != 0) m_pc = c.target;
    else if (c.br_en != 0 && c.br_taken != 0) begin
      off = (c.target >= 512) ? c.target - 1024 : c.target;
      m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
    end else m_pc = (m_pc + 1) % 1024;
    if (m_cnt < CMAX) m_cnt++;
    m_st = StFetch;
  endtask

  task automatic nop(); instr(0, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic build();
    // Straight-line program then HALT
    rst_cyc(); idle(2); go();
    for (int i = 0; i < 4; i++) nop();
    chk("model_cnt4", m_cnt, 4);
    pin(4); instr(2, 0, 0, 0, 0, 0, 0, 0); pin(4); hold(3);
    // Relative / not-taken / absolute branches
    rst_cyc(); go();
    for (int i = 0; i < 5; i++) nop();
    pin(5); instr(0, 1, 1, 0, 10'h3FE, 0, 0, 0); pin(3);
    nop(); nop();
    pin(5); instr(0, 1, 0, 0, 10'h3FE, 0, 0, 0); pin(6);
    instr(0, 1, 1, 0, 10'h3FF, 0, 0, 0);
    pin(5); instr(0, 1, 1, 1, 20, 0, 0, 0); pin(20);
    // PC wrap both directions
    instr(0, 1, 1, 1, 1023, 0, 0, 0); pin(1023);
    nop(); pin(0); nop(); pin(1);
    instr(0, 1, 1, 0, 10'h3FD, 0, 0, 0); pin(1022);
    // Memory: 4-cycle wait, ready on the limit cycle, then timeout
    instr(1, 0, 0, 0, 0, 4, 1, 0);
    instr(1, 0, 0, 0, 0, TMO, 1, 0);
    instr(1, 0, 0, 0, 0, TMO, 0, 0); hold(3);
    // HALT beats branch and mem_op
    rst_cyc(); go(); nop(); nop();
    pin(2); instr(2, 0, 0, 0, 0, 0, 0, 0); pin(2); hold(3);
    chk("model_halt_cnt", m_cnt, 2);
    // Async reset in WB at pc=7, then IDLE until start
    rst_cyc(); go();
    for (int i = 0; i < 7; i++) nop();
    pin(7); instr(0, 0, 0, 0, 0, 0, 0, 1);
    idle(4); go(); nop(); instr(2, 0, 0, 0, 0, 0, 0, 0); hold(2);
    // Counter saturation
    rst_cyc(); go();
    for (int i = 0; i < CMAX + 4; i++) nop();
    chk("model_cnt_sat", m_cnt, CMAX);
    instr(2, 0, 0, 0, 0, 0, 0, 0); hold(2);
    // Randomized programs
    for (int p = 0; p < 14; p++) begin
      int n;
      rst_cyc(); idle(int'($urandom_range(3))); go();
      n = int'($urandom_range(20, 4));
      for (int i = 0; i < n && m_st == StFetch; i++) begin
        int r = int'($urandom_range(99));
        int kind = (r < 6) ? 2 : (r < 30) ? 1 : 0;
        int rdy = int'($urandom_range(9) != 0);
        instr(kind, int'($urandom_range(1)), int'($urandom_range(1)), int'($urandom_range(1)),
              int'($urandom_range(1023)), int'($urandom_range(TMO, 1)), rdy,
              int'($urandom_range(39) == 0));
      end
      if (m_st == StFetch) instr(2, 0, 0, 0, 0, 0, 0, 0);
      if (m_st == StIdle) idle(2);
      else hold(2);
    end
  endtask

  initial begin
    build();
    foreach (q[i]) begin
      @(negedge clk);
      chk("state", int'(state), q[i].st);
      chk("pc", int'(pc), q[i].pc);
      chk("fetch_en", int'(fetch_en), q[i].fe);
      chk("wb_en", int'(wb_en), q[i].wb);
      chk("done", int'(done), q[i].dn);
      chk("fault", int'(fault), q[i].ft);
      chk("instr_cnt", int'(instr_cnt), q[i].cnt);
      if (q[i].lpc >= 0) chk("pc_literal", int'(pc), q[i].lpc);
      reset = q[i].rst[0]; start = q[i].start[0]; halt = q[i].halt[0];
      mem_op = q[i].mem_op[0]; mem_ready = q[i].mem_ready[0];
      branch_en = q[i].br_en[0]; branch_taken = q[i].br_taken[0];
      br_abs = q[i].br_abs[0]; target = q[i].target[PC_W-1:0];
      if (q[i].achk != 0) begin
        #1;
        chk("async_rst_state", int'(state), StIdle);
        chk("async_rst_pc", int'(pc), 0);
        chk("async_rst_wb_en", int'(wb_en), 0);
        chk("async_rst_fetch_en", int'(fetch_en), 0);
        chk("async_rst_done", int'(done), 0);
        chk("async_rst_fault", int'(fault), 0);
        chk("async_rst_cnt", int'(instr_cnt), 0);
      end
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
